// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: host command bridge to the CPU imem/dmem external ports and run control
module cpu_mem_loader #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 63
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_data,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        enable
);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_RESP} state_t;
  localparam logic [2:0] OP_START = 3'd4, OP_STOP = 3'd5, OP_STAT = 3'd6, OP_RSVD = 3'd7;
  localparam logic [7:0] LAT_M1 = 8'(RD_LAT - 1);

  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [63:0]      r_addr, r_data, r_rsp_data, r_budget;
  logic [7:0]       r_len, r_idx, r_wait;
  logic             r_rsp_err, r_rsp_last, r_running;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_mem_op, w_err, w_cap, w_hs, w_expire, w_rd;
  logic [63:0]      w_status;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_mem_op = !cmd_op[2];
  assign w_err    = cmd_op == OP_RSVD
                 || (w_mem_op && r_running)
                 || (cmd_op == OP_START && r_running)
                 || (w_mem_op && !cmd_op[0] && cmd_addr[1:0] != 2'd0)
                 || (w_mem_op && cmd_op[0] && cmd_addr[2:0] != 3'd0);
  assign w_rd     = r_op[2:1] == 2'b01;
  assign w_cap    = r_state == S_RD_WAIT && r_wait == 8'd0;
  assign w_hs     = rsp_valid && rsp_ready;
  assign w_expire = r_running && r_budget != 64'd0 && 64'(r_cnt) + 64'd1 == r_budget;
  assign w_status = {r_running, 63'(r_cnt)};

  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign rsp_last    = r_rsp_last;
  assign addr_ext    = r_addr;
  assign addr_ext_2  = r_addr;
  assign wdata_ext   = r_data[31:0];
  assign wdata_ext_2 = r_data;
  assign enable      = r_running;

  // command FSM state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // command FSM next state; errors and non-memory commands go straight to RESP
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_accept) w_next = (w_err || !w_mem_op) ? S_RESP : cmd_op[1] ? S_RD_REQ : S_WR;
      S_WR:      w_next = S_RESP;
      S_RD_REQ:  w_next = S_RD_WAIT;
      S_RD_WAIT: if (r_wait == 8'd0) w_next = S_RESP;
      S_RESP:    if (rsp_ready) w_next = (w_rd && !r_rsp_last) ? S_RD_REQ : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // handshake and memory strobes decoded from state; ready is held low during reset
  always_comb begin
    cmd_ready = arst_n && r_state == S_IDLE;
    rsp_valid = r_state == S_RESP;
    wen_ext   = r_state == S_WR && !r_op[0];
    wen_ext_2 = r_state == S_WR && r_op[0];
    ren_ext   = r_state == S_RD_REQ && !r_op[0];
    ren_ext_2 = r_state == S_RD_REQ && r_op[0];
  end

  // command latch, read latency timer, response registers and burst address walk
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_op       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_wait     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_last <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op       <= cmd_op;
        r_addr     <= cmd_addr;
        r_data     <= cmd_data;
        r_len      <= cmd_len;
        r_idx      <= 8'd0;
        r_rsp_data <= cmd_op == OP_STAT ? w_status : 64'd0;
        r_rsp_err  <= w_err;
        r_rsp_last <= 1'b1;
      end
      if (r_state == S_RD_REQ) r_wait <= LAT_M1;
      else if (r_state == S_RD_WAIT && r_wait != 8'd0) r_wait <= r_wait - 8'd1;
      if (w_cap) begin
        r_rsp_data <= r_op[0] ? rdata_ext_2 : {32'd0, rdata_ext};
        r_rsp_last <= r_idx == r_len;
      end
      if (w_hs && w_rd) begin
        r_addr <= r_addr + (r_op[0] ? 64'd8 : 64'd4);
        r_idx  <= r_idx + 8'd1;
      end
    end
  end

  // run flag, budget and saturating cycle counter; START restarts the count
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_running <= 1'b0;
      r_cnt     <= '0;
      r_budget  <= '0;
    end else if (w_accept && cmd_op == OP_START && !w_err) begin
      r_running <= 1'b1;
      r_cnt     <= '0;
      r_budget  <= cmd_data;
    end else begin
      if ((w_accept && cmd_op == OP_STOP) || w_expire) r_running <= 1'b0;
      if (r_running && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb_cpu_mem_loader: randomized self-checking bench with a transaction-level reference model
module tb_cpu_mem_loader;
  localparam logic [2:0] WRI = 3'd0, WRD = 3'd1, RDI = 3'd2, RDD = 3'd3, START = 3'd4, STOP = 3'd5, STAT = 3'd6, RSV = 3'd7;
  localparam longint INF = 64'h3fff_ffff_ffff_ffff;

  logic        clk = 1'b0, arst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_last;
  logic [2:0]  cmd_op = '0;
  logic [63:0] cmd_addr = '0, cmd_data = '0, rsp_data;
  logic [7:0]  cmd_len = '0;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2 = '0;
  logic [31:0] wdata_ext, rdata_ext = '0;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable;

  int checks = 0, errors = 0;

  cpu_mem_loader dut (
    .clk(clk), .arst_n(arst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
    .rdata_ext_2(rdata_ext_2), .enable(enable)
  );

  always #5 clk = ~clk;

  // CPU-side memories (RD_LAT = 1) plus activity counters
  logic [31:0] cpu_im [logic [63:0]];
  logic [63:0] cpu_dm [logic [63:0]];
  longint      cyc = 0;
  int          n_wen = 0, n_ren = 0, n_en = 0;
  logic [63:0] wa_i = '0;
  logic [31:0] wd_i = '0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    n_wen <= n_wen + int'(wen_ext) + int'(wen_ext_2);
    n_ren <= n_ren + int'(ren_ext) + int'(ren_ext_2);
    n_en  <= n_en + int'(enable);
    if (wen_ext) begin cpu_im[addr_ext] = wdata_ext; wa_i <= addr_ext; wd_i <= wdata_ext; end
    if (wen_ext_2) cpu_dm[addr_ext_2] = wdata_ext_2;
    if (ren_ext) rdata_ext <= cpu_im.exists(addr_ext) ? cpu_im[addr_ext] : 32'd0;
    if (ren_ext_2) rdata_ext_2 <= cpu_dm.exists(addr_ext_2) ? cpu_dm[addr_ext_2] : 64'd0;
  end

  // reference model: memory contents and run history as cycle numbers
  logic [31:0] m_im [logic [63:0]];
  logic [63:0] m_dm [logic [63:0]];
  bit          m_started = 0;
  longint      m_t0 = 0, m_b = 0, m_tstop = INF;
  logic [63:0] e_data[$], q_data[$];
  bit          e_err[$], e_last[$], q_err[$], q_last[$];
  longint      acc, first_vld;
  int          d_wen, d_ren, stall_bad;
  logic        en1;

  function automatic longint last_en();
    longint l = m_tstop;
    if (m_b != 0 && m_t0 + m_b < l) l = m_t0 + m_b;
    return l;
  endfunction

  function automatic bit run_at(longint t);
    return m_started && t > m_t0 && t <= last_en();
  endfunction

  function automatic longint cnt_at(longint t);
    longint hi;
    if (!m_started) return 0;
    hi = (t - 1 < last_en()) ? t - 1 : last_en();
    return hi > m_t0 ? hi - m_t0 : 0;
  endfunction

  task automatic model_cmd(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] len, input longint t);
    bit run, err;
    logic [63:0] a, v;
    e_data.delete(); e_err.delete(); e_last.delete();
    run = run_at(t);
    err = op == RSV || (op < 4 && run) || (op == START && run)
       || ((op == WRI || op == RDI) && addr[1:0] != 2'd0)
       || ((op == WRD || op == RDD) && addr[2:0] != 3'd0);
    if (err) begin e_data.push_back(64'd0); e_err.push_back(1); e_last.push_back(1); return; end
    if (op == RDI || op == RDD) begin
      for (int i = 0; i <= int'(len); i++) begin
        a = addr + 64'(i) * (op == RDI ? 64'd4 : 64'd8);
        if (op == RDI) v = m_im.exists(a) ? {32'd0, m_im[a]} : 64'd0;
        else           v = m_dm.exists(a) ? m_dm[a] : 64'd0;
        e_data.push_back(v); e_err.push_back(0); e_last.push_back(i == int'(len));
      end
      return;
    end
    v = 64'd0;
    if (op == WRI) m_im[addr] = data[31:0];
    if (op == WRD) m_dm[addr] = data;
    if (op == START) begin m_started = 1; m_t0 = t; m_b = longint'(data); m_tstop = INF; end
    if (op == STOP && m_started && t < m_tstop) m_tstop = t;
    if (op == STAT) v = {run, 63'(cnt_at(t))};
    e_data.push_back(v); e_err.push_back(0); e_last.push_back(1);
  endtask

  // issue one command and collect its responses, watching for changes while stalled
  task automatic run_cmd(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data,
                         input logic [7:0] len, input bit stall);
    int w0, r0, k;
    bit held, done;
    logic [65:0] hv;
    q_data.delete(); q_err.delete(); q_last.delete();
    first_vld = -1; stall_bad = 0; done = 0; held = 0; hv = '0;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_len = len;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (!cmd_ready) begin
      errors++; $display("FAIL cmd_accept op=%0d: cmd_ready=0, required 1 within 50 cycles", op);
      cmd_valid = 0; return;
    end
    acc = cyc; w0 = n_wen; r0 = n_ren;
    model_cmd(op, addr, data, len, acc);
    @(negedge clk);
    cmd_valid = 0; en1 = enable;
    for (k = 0; k < 400 && !done; k++) begin
      if (rsp_valid && first_vld < 0) first_vld = cyc;
      if (held && {rsp_valid, rsp_data, rsp_err, rsp_last} !== {1'b1, hv}) stall_bad++;
      rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      held = rsp_valid && !rsp_ready;
      hv = {rsp_data, rsp_err, rsp_last};
      if (rsp_valid && rsp_ready) begin
        q_data.push_back(rsp_data); q_err.push_back(rsp_err); q_last.push_back(rsp_last); done = rsp_last;
      end
      @(negedge clk);
    end
    rsp_ready = 0;
    d_wen = n_wen - w0; d_ren = n_ren - r0;
    checks++;
    if (!done) begin errors++; $display("FAIL rsp_last op=%0d: got %0d responses, no last within 400 cycles", op, q_data.size()); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last, addr_ext, wen_ext, ren_ext, wdata_ext,
         addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, enable} !== '0) begin
      errors++; $display("FAIL reset_outputs: ready=%b valid=%b en=%b addr=%h, required all 0", cmd_ready, rsp_valid, enable, addr_ext);
    end
    arst_n = 1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready); end
  endtask

  task automatic test_imem();
    run_cmd(WRI, 64'h8, 64'h0050_0093, 8'd0, 0);
    checks++;
    if ({d_wen, wa_i, wd_i} !== {32'd1, 64'h8, 32'h0050_0093}) begin
      errors++; $display("FAIL imem_write: wen_cycles=%0d addr=%h data=%h, required 1 8 00500093", d_wen, wa_i, wd_i);
    end
    checks++;
    if (first_vld != acc + 2 || q_data.size() != 1 || {q_data[0], q_err[0], q_last[0]} !== {64'd0, 2'b01}) begin
      errors++; $display("FAIL imem_write_rsp: vld_at=+%0d n=%0d, required +2 one ack", first_vld - acc, q_data.size());
    end
    run_cmd(RDI, 64'h8, 64'd0, 8'd0, 0);
    checks++;
    if (q_data.size() != 1 || {q_data[0], q_err[0], q_last[0]} !== {e_data[0], e_err[0], e_last[0]}) begin
      errors++; $display("FAIL imem_read: n=%0d data=%h, required 1 %h", q_data.size(), q_data[0], e_data[0]);
    end
    checks++;
    if (first_vld != acc + 3 || d_ren != 1) begin
      errors++; $display("FAIL imem_read_timing: vld_at=+%0d ren=%0d, required +3 1", first_vld - acc, d_ren);
    end
  endtask

  task automatic test_dmem_burst();
    for (int i = 0; i < 3; i++) run_cmd(WRD, 64'(8 * i), 64'(i + 1), 8'd0, 0);
    run_cmd(RDD, 64'h0, 64'd0, 8'd2, 1);
    checks++;
    if (q_data.size() != 3 || q_data[0] !== 64'd1 || q_data[1] !== 64'd2 || q_data[2] !== 64'd3
        || {q_last[0], q_last[1], q_last[2]} !== 3'b001 || e_data[2] !== 64'd3) begin
      errors++; $display("FAIL dmem_burst: n=%0d last=%b%b%b d2=%h, required 3 001 3", q_data.size(), q_last[0], q_last[1], q_last[2], q_data[2]);
    end
    checks++;
    if (stall_bad != 0 || d_ren != 3) begin
      errors++; $display("FAIL dmem_burst_stall: unstable=%0d ren=%0d, required 0 3", stall_bad, d_ren);
    end
    run_cmd(WRD, 64'hffff_ffff_ffff_fff8, 64'haa, 8'd0, 0);
    run_cmd(RDD, 64'hffff_ffff_ffff_fff8, 64'd0, 8'd1, 1);
    checks++;
    if (q_data.size() != 2 || q_data[0] !== e_data[0] || q_data[1] !== e_data[1] || q_last[1] !== 1'b1) begin
      errors++; $display("FAIL addr_wrap: n=%0d d0=%h d1=%h, required 2 %h %h", q_data.size(), q_data[0], q_data[1], e_data[0], e_data[1]);
    end
  endtask

  task automatic test_budget();
    int e0;
    e0 = n_en;
    run_cmd(START, 64'd0, 64'd5, 8'd0, 0);
    checks++;
    if (en1 !== 1'b1 || q_data[0] !== 64'd0) begin errors++; $display("FAIL start_enable: enable=%b at +1, required 1", en1); end
    repeat (10) @(negedge clk);
    checks++;
    if (n_en - e0 != 5) begin errors++; $display("FAIL budget: enable high %0d cycles, required 5", n_en - e0); end
    run_cmd(STAT, 64'd0, 64'd0, 8'd0, 0);
    checks++;
    if (q_data[0] !== 64'd5 || q_data[0] !== e_data[0] || first_vld != acc + 1) begin
      errors++; $display("FAIL budget_status: got %h at +%0d, required 5 at +1", q_data[0], first_vld - acc);
    end
  endtask

  task automatic test_run_err();
    run_cmd(START, 64'd0, 64'd0, 8'd0, 0);
    repeat (3) @(negedge clk);
    run_cmd(RDD, 64'h0, 64'd0, 8'd0, 0);
    checks++;
    if ({q_data[0], q_err[0], q_last[0]} !== {64'd0, 2'b11} || d_ren != 0) begin
      errors++; $display("FAIL read_while_running: data=%h err=%b ren=%0d, required 0 1 0", q_data[0], q_err[0], d_ren);
    end
    run_cmd(STOP, 64'd0, 64'd0, 8'd0, 0);
    checks++;
    if (en1 !== 1'b0 || q_err[0] !== 1'b0) begin errors++; $display("FAIL stop: enable=%b at +1, required 0", en1); end
    repeat (4) @(negedge clk);
    run_cmd(STAT, 64'd0, 64'd0, 8'd0, 0);
    checks++;
    if (q_data[0] !== e_data[0] || q_data[0][63] !== 1'b0) begin
      errors++; $display("FAIL stop_status: got %h, required %h", q_data[0], e_data[0]);
    end
  endtask

  task automatic test_errors();
    logic [2:0]  ops [6] = '{WRI, RDI, WRD, RDD, RSV, START};
    logic [63:0] ads [6] = '{64'h2, 64'h2, 64'h4, 64'h4, 64'h0, 64'h0};
    run_cmd(START, 64'd0, 64'd0, 8'd0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) run_cmd(STOP, 64'd0, 64'd0, 8'd0, 0);
      if (i == 5) run_cmd(START, 64'd0, 64'd0, 8'd0, 0);
      run_cmd(ops[i], ads[i], 64'h1234, 8'd3, 0);
      checks++;
      if (q_data.size() != 1 || {q_data[0], q_err[0], q_last[0]} !== {64'd0, 2'b11} || d_wen + d_ren != 0) begin
        errors++; $display("FAIL error_%0d op=%0d: n=%0d data=%h err=%b last=%b acc=%0d, required 1 0 1 1 0", i, ops[i], q_data.size(), q_data[0], q_err[0], q_last[0], d_wen + d_ren);
      end
    end
    run_cmd(STOP, 64'd0, 64'd0, 8'd0, 0);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [63:0] a, d;
    logic [7:0] len;
    int r, exp_acc;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 15);
      op = r < 3 ? WRI : r < 6 ? WRD : r < 8 ? RDI : r < 10 ? RDD : r == 10 ? START : r < 13 ? STOP : r < 15 ? STAT : RSV;
      a = (op == WRI || op == RDI) ? 64'($urandom_range(0, 15)) << 2 : 64'($urandom_range(0, 15)) << 3;
      if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 3));
      d = op == START ? 64'($urandom_range(0, 12)) : {$urandom, $urandom};
      len = 8'($urandom_range(0, 3));
      run_cmd(op, a, d, len, 1'($urandom_range(0, 1)));
      checks++;
      if (q_data.size() != e_data.size()) begin
        errors++; $display("FAIL rand_%0d op=%0d: %0d responses, required %0d", n, op, q_data.size(), e_data.size());
      end else foreach (e_data[i]) if ({q_data[i], q_err[i], q_last[i]} !== {e_data[i], e_err[i], e_last[i]}) begin
        errors++; $display("FAIL rand_%0d op=%0d word %0d: %h/%b/%b, required %h/%b/%b", n, op, i, q_data[i], q_err[i], q_last[i], e_data[i], e_err[i], e_last[i]);
      end
      exp_acc = e_err[0] ? 0 : op < 2 ? 1 : op < 4 ? int'(len) + 1 : 0;
      checks++;
      if (d_wen + d_ren != exp_acc || stall_bad != 0) begin
        errors++; $display("FAIL rand_%0d_access op=%0d: accesses=%0d unstable=%0d, required %0d 0", n, op, d_wen + d_ren, stall_bad, exp_acc);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        @(negedge clk);
        cmd_valid = 1; cmd_op = RDD; cmd_addr = 64'h0; cmd_len = 8'd7; rsp_ready = 1;
        @(negedge clk);
        cmd_valid = 0;
        repeat (5) @(negedge clk);
      end else begin
        run_cmd(START, 64'd0, 64'd0, 8'd0, 0);
        repeat (4) @(negedge clk);
      end
      #2 arst_n = 0;
      r0 = n_ren + n_wen;
      m_started = 0;
      #1;
      checks++;
      if ({cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_last, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, enable} !== '0) begin
        errors++; $display("FAIL reset_mid_%0d: ready=%b valid=%b ren2=%b en=%b, required all 0", s, cmd_ready, rsp_valid, ren_ext_2, enable);
      end
      repeat (3) @(negedge clk);
      arst_n = 1; rsp_ready = 0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || n_ren + n_wen != r0 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid_%0d_release: ready=%b accesses=%0d valid=%b, required 1 0 0", s, cmd_ready, n_ren + n_wen - r0, rsp_valid);
      end
      run_cmd(STAT, 64'd0, 64'd0, 8'd0, 0);
      checks++;
      if (q_data[0] !== 64'd0 || q_data[0] !== e_data[0]) begin
        errors++; $display("FAIL reset_mid_%0d_status: got %h, required 0", s, q_data[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_imem();
    test_dmem_burst();
    test_budget();
    test_run_err();
    test_errors();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
